// File: rtl/register_4b_reader_if.sv
// Request, bank-select and result handshake bundle for register_4b_reader.
// The slave modport is the reader's view; master is the requester/bank/consumer side.
interface register_4b_reader_if #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
);
  logic                input_req_valid;
  logic                output_req_ready;
  logic [ADDR_W-1:0]   input_req_addr;
  logic [NUM_REGS-1:0] output_reg_sel;
  logic [3:0]          input_reg_q;
  logic                output_data_valid;
  logic                input_data_ready;
  logic [3:0]          output_data;
  logic [ADDR_W-1:0]   output_data_addr;
  logic                output_error;

  modport slave (
    input  input_req_valid, input_req_addr, input_reg_q, input_data_ready,
    output output_req_ready, output_reg_sel, output_data_valid,
    output output_data, output_data_addr, output_error
  );

  modport master (
    output input_req_valid, input_req_addr, input_reg_q, input_data_ready,
    input  output_req_ready, output_reg_sel, output_data_valid,
    input  output_data, output_data_addr, output_error
  );
endinterface

// File: rtl/register_4b_reader.sv
// Read-side sequencer for a bank of 4-bit registers: one-cycle SELECT stage
// driving a one-hot output-enable, followed by a 2-entry result FIFO.
module register_4b_reader #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                 clock,
  input  logic                 input_clear_n,
  register_4b_reader_if.slave  bus
);

  localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W + 1)'(NUM_REGS);

  logic              r_selValid;
  logic [ADDR_W-1:0] r_selAddr;
  logic [3:0]        r_bufData [2];
  logic [ADDR_W-1:0] r_bufAddr [2];
  logic              r_wrPtr;
  logic              r_rdPtr;
  logic [1:0]        r_count;
  logic              r_error;

  logic [1:0]          w_inFlight;
  logic                w_reqReady;
  logic                w_reqFire;
  logic                w_reqInRange;
  logic                w_selInRange;
  logic                w_push;
  logic                w_pop;
  logic [3:0]          w_pushData;
  logic [NUM_REGS-1:0] w_sel;

  // Ready counts the SELECT stage as occupied so a push can never find the FIFO full.
  assign w_inFlight   = r_count + {1'b0, r_selValid};
  assign w_reqReady   = (w_inFlight < 2'd2);
  assign w_reqFire    = bus.input_req_valid && w_reqReady;
  assign w_reqInRange = ({1'b0, bus.input_req_addr} < LP_NUM_REGS);
  assign w_selInRange = ({1'b0, r_selAddr} < LP_NUM_REGS);
  assign w_push       = r_selValid;
  assign w_pop        = (r_count != 2'd0) && bus.input_data_ready;
  assign w_pushData   = w_selInRange ? bus.input_reg_q : 4'h0;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (r_selValid && (r_selAddr == ADDR_W'(i))) begin
        w_sel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!input_clear_n) begin
      r_selValid <= 1'b0;
      r_selAddr  <= '0;
      r_bufData  <= '{default: 4'h0};
      r_bufAddr  <= '{default: '0};
      r_wrPtr    <= 1'b0;
      r_rdPtr    <= 1'b0;
      r_count    <= 2'd0;
      r_error    <= 1'b0;
    end else begin
      r_selValid <= w_reqFire;
      if (w_reqFire) begin
        r_selAddr <= bus.input_req_addr;
      end
      if (w_reqFire && !w_reqInRange) begin
        r_error <= 1'b1;
      end
      // Q is captured from the pre-edge bus, so a same-edge bank write is not seen.
      if (w_push) begin
        r_bufData[r_wrPtr] <= w_pushData;
        r_bufAddr[r_wrPtr] <= r_selAddr;
        r_wrPtr            <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.output_req_ready  = w_reqReady;
  assign bus.output_reg_sel    = w_sel;
  assign bus.output_data_valid = (r_count != 2'd0);
  assign bus.output_data       = r_bufData[r_rdPtr];
  assign bus.output_data_addr  = r_bufAddr[r_rdPtr];
  assign bus.output_error      = r_error;

endmodule

// File: tb/tb_register_4b_reader.sv
// Self-checking bench for register_4b_reader with a 3-register bank so that
// address 3 exercises the out-of-range path.
module tb_register_4b_reader;

  localparam int NUM_REGS = 3;
  localparam int ADDR_W   = 2;

  logic clock = 1'b0;
  logic input_clear_n;

  register_4b_reader_if #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) bus ();

  register_4b_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clock         (clock),
    .input_clear_n (input_clear_n),
    .bus           (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Register bank model: written at the clock edge, drives Q only for the enabled register.
  logic [3:0] bank [NUM_REGS];
  logic       wrEn;
  logic [1:0] wrAddr;
  logic [3:0] wrData;
  logic [3:0] junk = 4'h5;
  logic [3:0] qBus;

  always @(posedge clock) begin
    if (wrEn && int'(wrAddr) < NUM_REGS) bank[wrAddr] <= wrData;
  end

  always @(negedge clock) junk <= 4'($urandom_range(1, 15));

  always_comb begin
    qBus = junk;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.output_reg_sel[i]) qBus = bank[i];
    end
  end
  assign bus.input_reg_q = qBus;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: requests in flight and buffered results as plain queues.
  typedef struct packed {
    logic [3:0] data;
    logic [1:0] addr;
  } entry_t;

  entry_t     mFifo[$];
  logic       mSelValid = 1'b0;
  logic [1:0] mSelAddr = 2'd0;
  logic       mError = 1'b0;
  logic       mLive = 1'b0;
  logic       mFire;
  logic       mPop;
  entry_t     mEntry;
  logic [2:0] expSel;

  function automatic logic modelReady();
    return (mFifo.size() + int'(mSelValid)) < 2;
  endfunction

  always @(posedge clock) begin
    if (input_clear_n === 1'b0) begin
      mFifo.delete();
      mSelValid = 1'b0;
      mSelAddr  = 2'd0;
      mError    = 1'b0;
      mLive     = 1'b1;
    end else if (mLive) begin
      mFire = bus.input_req_valid && modelReady();
      mPop  = (mFifo.size() != 0) && bus.input_data_ready;
      if (mPop) void'(mFifo.pop_front());
      if (mSelValid) begin
        mEntry.addr = mSelAddr;
        mEntry.data = (int'(mSelAddr) < NUM_REGS) ? bank[mSelAddr] : 4'h0;
        mFifo.push_back(mEntry);
      end
      if (mFire && int'(bus.input_req_addr) >= NUM_REGS) mError = 1'b1;
      mSelValid = mFire;
      mSelAddr  = bus.input_req_addr;
    end
  end

  always @(negedge clock) begin
    if (mLive) begin
      expSel = 3'b000;
      if (mSelValid && int'(mSelAddr) < NUM_REGS) expSel[mSelAddr] = 1'b1;
      checkOutput("req_ready", 8'(bus.output_req_ready), 8'(modelReady()));
      checkOutput("reg_sel", 8'(bus.output_reg_sel), 8'(expSel));
      checkOutput("data_valid", 8'(bus.output_data_valid), 8'(mFifo.size() != 0));
      checkOutput("error", 8'(bus.output_error), 8'(mError));
      if (mFifo.size() != 0) begin
        checkOutput("data", 8'(bus.output_data), 8'(mFifo[0].data));
        checkOutput("data_addr", 8'(bus.output_data_addr), 8'(mFifo[0].addr));
      end
    end
  end

  logic [3:0] gotQ[$];

  task automatic applyStimulus(input logic v, input logic [1:0] a, input logic rdy,
                               input logic we, input logic [1:0] wa, input logic [3:0] wd);
    bus.input_req_valid  = v;
    bus.input_req_addr   = a;
    bus.input_data_ready = rdy;
    wrEn   = we;
    wrAddr = wa;
    wrData = wd;
    if (bus.output_data_valid === 1'b1 && rdy) gotQ.push_back(bus.output_data);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic printSummary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  initial begin
    #400000;
    errors++;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    printSummary();
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int next;
    logic accept;
    logic [3:0] expSeq [3];

    input_clear_n        = 1'b0;
    bus.input_req_valid  = 1'b0;
    bus.input_req_addr   = 2'd0;
    bus.input_data_ready = 1'b0;
    wrEn   = 1'b0;
    wrAddr = 2'd0;
    wrData = 4'h0;
    @(negedge clock);

    // Reset while presetting the bank
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 2'd0, 4'h1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 4'h2);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 4'hA);
    checkOutput("rst_ready", 8'(bus.output_req_ready), 8'd1);
    checkOutput("rst_sel", 8'(bus.output_reg_sel), 8'd0);
    checkOutput("rst_valid", 8'(bus.output_data_valid), 8'd0);
    checkOutput("rst_data", 8'(bus.output_data), 8'd0);
    checkOutput("rst_addr", 8'(bus.output_data_addr), 8'd0);
    checkOutput("rst_error", 8'(bus.output_error), 8'd0);
    input_clear_n = 1'b1;

    // Single read of r2
    gotQ.delete();
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("single_sel", 8'(bus.output_reg_sel), 8'b100);
    checkOutput("single_valid_early", 8'(bus.output_data_valid), 8'd0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("single_sel_off", 8'(bus.output_reg_sel), 8'd0);
    checkOutput("single_valid", 8'(bus.output_data_valid), 8'd1);
    checkOutput("single_data", 8'(bus.output_data), 8'hA);
    checkOutput("single_addr", 8'(bus.output_data_addr), 8'd2);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("single_popped", 8'(bus.output_data_valid), 8'd0);
    checkOutput("single_count", 8'(gotQ.size()), 8'd1);

    // Streaming with the consumer always ready
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 4'h3);
    gotQ.delete();
    next = 0;
    for (int c = 0; c < 40 && gotQ.size() < 3; c++) begin
      accept = (next < 3) && modelReady();
      applyStimulus(next < 3, 2'(next), 1'b1, 1'b0, 2'd0, 4'h0);
      if (accept) next++;
    end
    expSeq = '{4'h1, 4'h2, 4'h3};
    checkOutput("stream_count", 8'(gotQ.size()), 8'd3);
    for (int i = 0; i < 3 && i < gotQ.size(); i++) checkOutput("stream_data", 8'(gotQ[i]), 8'(expSeq[i]));

    // Backpressure: consumer stalled while requests 0,1,2 are offered
    gotQ.delete();
    next = 0;
    for (int c = 0; c < 6; c++) begin
      accept = (next < 3) && modelReady();
      applyStimulus(next < 3, 2'(next), 1'b0, 1'b0, 2'd0, 4'h0);
      if (accept) next++;
    end
    checkOutput("bp_accepted", 8'(next), 8'd2);
    checkOutput("bp_ready", 8'(bus.output_req_ready), 8'd0);
    checkOutput("bp_valid", 8'(bus.output_data_valid), 8'd1);
    checkOutput("bp_data", 8'(bus.output_data), 8'h1);
    checkOutput("bp_addr", 8'(bus.output_data_addr), 8'd0);
    for (int c = 0; c < 40 && gotQ.size() < 3; c++) begin
      accept = (next < 3) && modelReady();
      applyStimulus(next < 3, 2'(next), 1'b1, 1'b0, 2'd0, 4'h0);
      if (accept) next++;
    end
    checkOutput("bp_count", 8'(gotQ.size()), 8'd3);
    for (int i = 0; i < 3 && i < gotQ.size(); i++) checkOutput("bp_data_seq", 8'(gotQ[i]), 8'(expSeq[i]));

    // Read/write race on r1
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 4'h3);
    gotQ.delete();
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 4'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 4'hC);
    checkOutput("race_old", 8'(bus.output_data), 8'h3);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0);
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 4'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("race_new", 8'(bus.output_data), 8'hC);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("race_count", 8'(gotQ.size()), 8'd2);

    // Out-of-range address 3
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("oor_sel", 8'(bus.output_reg_sel), 8'd0);
    checkOutput("oor_error", 8'(bus.output_error), 8'd1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0);
    checkOutput("oor_valid", 8'(bus.output_data_valid), 8'd1);
    checkOutput("oor_data", 8'(bus.output_data), 8'h0);
    checkOutput("oor_addr", 8'(bus.output_data_addr), 8'd3);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0);
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("oor_sticky", 8'(bus.output_error), 8'd1);

    // Reset with two results buffered and the consumer stalled
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 4'h0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0);
    checkOutput("mid_full_ready", 8'(bus.output_req_ready), 8'd0);
    input_clear_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 4'h0);
    input_clear_n = 1'b1;
    checkOutput("mid_valid", 8'(bus.output_data_valid), 8'd0);
    checkOutput("mid_sel", 8'(bus.output_reg_sel), 8'd0);
    checkOutput("mid_error", 8'(bus.output_error), 8'd0);
    checkOutput("mid_ready", 8'(bus.output_req_ready), 8'd1);
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0);
    checkOutput("mid_read_valid", 8'(bus.output_data_valid), 8'd1);
    checkOutput("mid_read_data", 8'(bus.output_data), 8'h1);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0);

    // Random traffic, bank writes and occasional resets against the model
    for (int c = 0; c < 500; c++) begin
      input_clear_n = ($urandom_range(0, 59) != 0);
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0),
                    2'($urandom_range(0, 2)), 4'($urandom));
    end
    input_clear_n = 1'b1;
    for (int c = 0; c < 6; c++) applyStimulus(1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'h0);

    printSummary();
    $finish;
  end

endmodule
